spad_event_counter: RTL and testbench



---
 rtl/spad_event_counter.sv | 153 +++++++++++++++
 tb/tb_spad_event_counter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spad_event_counter.sv
// SPAD receive path: synchronises the avalanche comparator, issues quench
// requests, applies a dead-time and counts photon events per gate window.
module spad_event_counter #(
    parameter int CNT_W          = 16,
    parameter int GATE_CYCLES    = 10000,
    parameter int HOLDOFF_CYCLES = 8,
    parameter int GATE_W         = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             aval_in,
    input  logic             enable,
    output logic             quench_req,
    output logic             holdoff_active,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
    output logic             overflow,
    output logic [3:0]       led
);

    localparam int HO_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [HO_W-1:0]   HOLD_LOAD = HO_W'(HOLDOFF_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               aval_s1_q, aval_s2_q, aval_d_q;
    logic [HO_W-1:0]    hold_q, hold_d;
    logic [GATE_W-1:0]  gate_q, gate_d;
    logic [CNT_W-1:0]   events_q, events_d;
    logic               sat_q, sat_d;
    logic               quench_q, quench_d;
    logic [CNT_W-1:0]   count_out_q, count_out_d;
    logic               overflow_q, overflow_d;
    logic               valid_q, valid_d;
    logic               toggle_q, toggle_d;
    logic               led_en_q;
    logic               aval_edge;

    assign aval_edge = aval_s2_q & ~aval_d_q;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        gate_d      = gate_q;
        events_d    = events_q;
        sat_d       = sat_q;
        quench_d    = 1'b0;
        count_out_d = count_out_q;
        overflow_d  = overflow_q;
        valid_d     = 1'b0;
        toggle_d    = toggle_q;

        if (!enable) begin
            // Abort: partial window is discarded, published results are kept.
            state_d  = IDLE;
            gate_d   = '0;
            events_d = '0;
            sat_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = ARMED;
                    gate_d   = '0;
                    events_d = '0;
                    sat_d    = 1'b0;
                end
                ARMED: begin
                    if (aval_edge) begin
                        quench_d = 1'b1;
                        if (&events_q) begin
                            sat_d = 1'b1;
                        end else begin
                            events_d = events_q + CNT_W'(1);
                        end
                        hold_d  = HOLD_LOAD;
                        state_d = HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    // A diode stuck high keeps us here until the line drops.
                    if (hold_q != '0) begin
                        hold_d = hold_q - HO_W'(1);
                    end else if (!aval_s2_q) begin
                        state_d = ARMED;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (state_q != IDLE) begin
                if (gate_q == GATE_LAST) begin
                    count_out_d = events_d;
                    overflow_d  = sat_d;
                    valid_d     = 1'b1;
                    toggle_d    = ~toggle_q;
                    events_d    = '0;
                    sat_d       = 1'b0;
                    gate_d      = '0;
                end else begin
                    gate_d = gate_q + GATE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aval_s1_q   <= 1'b0;
            aval_s2_q   <= 1'b0;
            aval_d_q    <= 1'b0;
            state_q     <= IDLE;
            hold_q      <= '0;
            gate_q      <= '0;
            events_q    <= '0;
            sat_q       <= 1'b0;
            quench_q    <= 1'b0;
            count_out_q <= '0;
            overflow_q  <= 1'b0;
            valid_q     <= 1'b0;
            toggle_q    <= 1'b0;
            led_en_q    <= 1'b0;
        end else begin
            aval_s1_q   <= aval_in;
            aval_s2_q   <= aval_s1_q;
            aval_d_q    <= aval_s2_q;
            state_q     <= state_d;
            hold_q      <= hold_d;
            gate_q      <= gate_d;
            events_q    <= events_d;
            sat_q       <= sat_d;
            quench_q    <= quench_d;
            count_out_q <= count_out_d;
            overflow_q  <= overflow_d;
            valid_q     <= valid_d;
            toggle_q    <= toggle_d;
            led_en_q    <= enable;
        end
    end

    assign quench_req     = quench_q;
    assign holdoff_active = (state_q == HOLDOFF);
    assign count_out      = count_out_q;
    assign count_valid    = valid_q;
    assign overflow       = overflow_q;
    assign led            = {overflow_q, toggle_q, holdoff_active, led_en_q};

endmodule

// File: tb/tb_spad_event_counter.sv
// Bench for spad_event_counter: directed scenarios then random avalanche
// traffic, every cycle compared against a behavioural model.
module tb_spad_event_counter;

    // CNT_W=3: with an 8-cycle dead-time at most ~11 events fit in a
    // 100-cycle window, so a 3-bit counter is what makes saturation reachable.
    localparam int CNT_W   = 3;
    localparam int GATE    = 100;
    localparam int HOLD    = 8;
    localparam int GATE_W  = 7;
    localparam int MAXC    = (1 << CNT_W) - 1;
    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_HOLD  = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             aval_in;
    logic             enable;
    logic             quench_req;
    logic             holdoff_active;
    logic [CNT_W-1:0] count_out;
    logic             count_valid;
    logic             overflow;
    logic [3:0]       led;

    spad_event_counter #(
        .CNT_W(CNT_W), .GATE_CYCLES(GATE), .HOLDOFF_CYCLES(HOLD), .GATE_W(GATE_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .aval_in(aval_in), .enable(enable),
        .quench_req(quench_req), .holdoff_active(holdoff_active),
        .count_out(count_out), .count_valid(count_valid),
        .overflow(overflow), .led(led)
    );

    always #50 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    int s1 = 0, s2 = 0, sd = 0;
    int m_mode = M_IDLE, m_hold = 0, m_gate = 0, m_events = 0, m_sat = 0;
    int e_q = 0, e_cv = 0, e_cnt = 0, e_ovf = 0, e_tog = 0, e_en = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge of the specified behaviour, using the inputs seen at that edge.
    task automatic model_edge();
        int seen;
        int ev;
        int st;
        if (!rst_n) begin
            m_mode = M_IDLE; m_hold = 0; m_gate = 0; m_events = 0; m_sat = 0;
            e_q = 0; e_cv = 0; e_cnt = 0; e_ovf = 0; e_tog = 0; e_en = 0;
            s1 = 0; s2 = 0; sd = 0;
        end else begin
            seen = (s2 == 1 && sd == 0) ? 1 : 0;
            e_q  = 0;
            e_cv = 0;
            e_en = int'(enable);
            if (!enable) begin
                m_mode = M_IDLE; m_gate = 0; m_events = 0; m_sat = 0;
            end else if (m_mode == M_IDLE) begin
                m_mode = M_ARMED; m_gate = 0;
            end else begin
                ev = m_events;
                st = m_sat;
                if (m_mode == M_ARMED && seen == 1) begin
                    e_q = 1;
                    if (ev == MAXC) st = 1;
                    else ev = ev + 1;
                    m_mode = M_HOLD;
                    m_hold = HOLD - 1;
                end else if (m_mode == M_HOLD) begin
                    if (m_hold > 0) m_hold = m_hold - 1;
                    else if (s2 == 0) m_mode = M_ARMED;
                end
                if (m_gate == GATE - 1) begin
                    e_cnt = ev; e_ovf = st; e_cv = 1; e_tog = 1 - e_tog;
                    ev = 0; st = 0; m_gate = 0;
                end else begin
                    m_gate = m_gate + 1;
                end
                m_events = ev;
                m_sat = st;
            end
            sd = s2; s2 = s1; s1 = int'(aval_in);
        end
    endtask

    task automatic step();
        int hold_flag;
        @(posedge clk);
        model_edge();
        #1;
        hold_flag = (m_mode == M_HOLD) ? 1 : 0;
        check("quench_req", quench_req, e_q);
        check("holdoff_active", holdoff_active, hold_flag);
        check("count_valid", count_valid, e_cv);
        check("count_out", count_out, e_cnt);
        check("overflow", overflow, e_ovf);
        check("led", led, e_ovf * 8 + e_tog * 4 + hold_flag * 2 + e_en);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse(input int w);
        aval_in = 1'b1;
        for (int i = 0; i < w; i++) step();
        aval_in = 1'b0;
    endtask

    task automatic wait_cv(input int bound, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!count_valid && n < bound);
        check("cv_timeout", count_valid, 1);
    endtask

    initial begin
        int n;
        int hc;
        int saw_cv;
        rst_n = 1'b0; enable = 1'b0; aval_in = 1'b0;

        // Reset with a toggling input
        for (int i = 0; i < 3; i++) begin
            aval_in = ~aval_in;
            step();
            check("rst_outputs", {quench_req, holdoff_active, count_valid, overflow, count_out, led}, 0);
        end
        rst_n = 1'b1; enable = 1'b1; aval_in = 1'b0;
        wait_cv(300, n);
        check("first_cv_latency", n, GATE + 1);
        check("first_count", count_out, 0);

        // Single event: latency, dead-time length, count
        aval_in = 1'b1;
        step(); step();
        check("quench_early", quench_req, 0);
        step();
        check("quench_lat3", quench_req, 1);
        aval_in = 1'b0;
        hc = holdoff_active ? 1 : 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (holdoff_active) hc++;
        end
        check("holdoff_len", hc, HOLD);
        wait_cv(200, n);
        check("single_count", count_out, 1);
        check("single_ovf", overflow, 0);

        // Hold-off rejection, then a pulse outside the dead-time
        pulse(3); idle(1); pulse(3);
        wait_cv(200, n);
        check("reject_count", count_out, 1);
        pulse(3); idle(12); pulse(3);
        wait_cv(200, n);
        check("accept_count", count_out, 2);

        // Stuck-high input
        pulse(40);
        check("stuck_hold", holdoff_active, 1);
        hc = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (holdoff_active) hc++;
            else break;
        end
        check("stuck_release", hc, 2);
        wait_cv(200, n);
        check("stuck_count", count_out, 1);

        // Saturation then a quiet window
        for (int i = 0; i < 9; i++) begin
            pulse(2); idle(9);
        end
        wait_cv(200, n);
        check("sat_count", count_out, MAXC);
        check("sat_ovf", overflow, 1);
        wait_cv(200, n);
        check("quiet_count", count_out, 0);
        check("quiet_ovf", overflow, 0);

        // Event landing in the terminal gate cycle
        idle(GATE - 3);
        aval_in = 1'b1;
        wait_cv(200, n);
        check("term_count", count_out, 1);
        aval_in = 1'b0;
        wait_cv(200, n);
        check("after_term_count", count_out, 0);

        // Abort mid-window, then re-enable
        pulse(2); idle(12); pulse(2);
        wait_cv(200, n);
        check("pre_abort_count", count_out, 2);
        for (int i = 0; i < 3; i++) begin
            pulse(2); idle(13);
        end
        idle(5);
        enable = 1'b0;
        saw_cv = 0;
        for (int i = 0; i < 150; i++) begin
            step();
            if (count_valid) saw_cv = 1;
        end
        check("abort_no_cv", saw_cv, 0);
        check("abort_hold_count", count_out, 2);
        enable = 1'b1;
        step();
        pulse(2);
        wait_cv(200, n);
        check("reenable_count", count_out, 1);

        // Random traffic with occasional enable drops and resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) aval_in = ~aval_in;
            if ($urandom_range(0, 399) == 0) enable = ~enable;
            rst_n = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
